lut_sink: RTL
=============

Name: lut_sink

Overview:
- Receiving end of the 8-bit LUT stream (ltdata/ltvalid/ltready/ltlast).
- Accepts one DEPTH-entry signed-byte LUT frame into local storage and checks frame length.
- Accumulates a signed checksum over the frame.
- Exposes a 1-cycle-latency random read port to the rectification datapath once the table is loaded.

Parameters:
DEPTH, 160, number of LUT entries per frame
DW, 8, LUT entry width (signed two's complement)
AW, 8, read/write address width; must satisfy 2^AW >= DEPTH

Ports:
clk  input  1  single clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; arms a load from IDLE or DONE
ltdata  input  DW  stream data byte
ltvalid  input  1  stream data valid
ltlast  input  1  marks final byte of the frame
ltready  output  1  sink ready
hold  input  1  downstream backpressure request; deasserts ltready in LOAD
rd_addr  input  AW  LUT read address
rd_data  output  DW  LUT read data, registered
lut_ok  output  1  table loaded and length-checked
lut_err  output  1  last load failed the length check
busy  output  1  load or drain in progress
checksum  output  16  signed sum of accepted bytes, modulo 2^16

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE.
  - wr_cnt=0, ltready=0, lut_ok=0, lut_err=0, busy=0, checksum=0, rd_data=0.
  - Memory contents are not reset.
- Beat definition: beat = ltvalid && ltready. Data is transferred only on a beat.
- ltready is combinational from registered state and hold:
  - LOAD: ltready = !hold.
  - DRAIN: ltready = 1; hold is ignored.
  - All other states: ltready = 0.
- busy = 1 in LOAD and DRAIN, otherwise 0.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - On start: go to LOAD; clear wr_cnt, checksum, lut_ok and lut_err at the same edge.
- LOAD, on each beat:
  - Write mem[wr_cnt] <= ltdata.
  - checksum <= checksum + sign_extend16(ltdata).
  - wr_cnt <= wr_cnt + 1.
- LOAD, frame-end and error cases (evaluated on a beat):
  - ltlast and wr_cnt == DEPTH-1: go to DONE, lut_ok <= 1.
  - ltlast and wr_cnt < DEPTH-1 (short frame): go to IDLE, lut_err <= 1.
  - !ltlast and wr_cnt == DEPTH-1 (overrun): the byte is written; go to DRAIN, lut_err <= 1.
  - No beat: all state holds.
- DRAIN:
  - Accept and discard beats; no writes, no checksum update.
  - On a beat with ltlast: go to IDLE.
  - lut_err stays 1.
- DONE:
  - lut_ok held at 1.
  - On start: reload as from IDLE, with lut_ok dropping at that same edge.
- start while in LOAD or DRAIN is ignored.
- Read port:
  - rd_data <= mem[rd_addr] every cycle (1-cycle latency), in every state.
  - rd_addr >= DEPTH returns 0.
  - A read and a write to the same address in the same cycle return the old contents (read-first).
  - Consumers qualify read data with lut_ok.
- Checksum wraps modulo 2^16 with no saturation; the value is held after DONE or error until the next start.
- Reset mid-load: immediate return to the reset values above; a subsequent start performs a clean full load.
- lut_ok and lut_err are never 1 simultaneously.

Test Plan:
1. Nominal load:
   - Stimulus: start, then 160 continuous beats of 0x00..0x9F, ltlast on byte 159, hold=0.
   - Response: 160 beats in 160 cycles; lut_ok=1 in the cycle after the last beat; checksum=0x11B0 (8128 - 3600); lut_err=0.
   - Readback: rd_addr=5 gives rd_data=0x05 one cycle later; rd_addr=0x90 gives 0x90; rd_addr=200 gives 0x00.
2. Backpressure:
   - Stimulus: same frame with ltvalid held high and hold toggling 1/0 every cycle.
   - Response: ltready low on every hold=1 cycle and no write then; frame completes in 320 cycles; contents and checksum identical to scenario 1.
3. Short frame:
   - Stimulus: ltlast on beat 100 (wr_cnt=99).
   - Response: lut_err=1, lut_ok=0, state IDLE, ltready=0 the cycle after; checksum covers exactly 100 bytes.
4. Overrun:
   - Stimulus: 170-byte frame, ltlast on byte 169.
   - Response: lut_err=1 after beat 160; ltready stays 1 for 10 more beats even with hold=1; mem[159] holds byte 159; entries are not overwritten; IDLE after the ltlast beat.
5. Reset mid-load:
   - Stimulus: rst_n pulsed low at beat 80.
   - Response: ltready=0 asynchronously; checksum=0, lut_ok=0, busy=0; a following start plus nominal frame yields scenario-1 results.
6. Reload:
   - Stimulus: start during LOAD, then start while in DONE followed by a frame of all 0xFF.
   - Response: start during LOAD has no effect; start in DONE drops lut_ok and clears checksum at that edge; the 0xFF frame gives checksum=0xFF60 (-160); lut_ok returns.

Source files
------------

// File: rtl/lut_sink_if.sv
// 8-bit LUT stream bundle: source drives data/valid/last, sink returns ready.
interface lut_sink_if #(
  parameter int unsigned DW = 8
) ();
  logic [DW-1:0] ltdata;
  logic          ltvalid;
  logic          ltlast;
  logic          ltready;

  modport master (output ltdata, output ltvalid, output ltlast, input ltready);
  modport slave  (input ltdata, input ltvalid, input ltlast, output ltready);
endinterface

// File: rtl/lut_sink.sv
// LUT stream sink: loads one DEPTH-entry signed-byte frame, length-checks it,
// sums a 16-bit checksum and serves a registered random-read port.
module lut_sink #(
  parameter int unsigned DEPTH = 160,
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          hold,
  lut_sink_if.slave     lt,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          lut_ok,
  output logic          lut_err,
  output logic          busy,
  output logic [15:0]   checksum
);

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  state_e        state;
  logic [AW-1:0] wr_cnt;
  logic          beat;
  logic          wr_en;
  logic [DW-1:0] mem [DEPTH];

  always_comb begin
    lt.ltready = 1'b0;
    unique case (state)
      StLoad:  lt.ltready = !hold;
      StDrain: lt.ltready = 1'b1;
      default: lt.ltready = 1'b0;
    endcase
  end

  assign beat  = lt.ltvalid && lt.ltready;
  assign wr_en = (state == StLoad) && beat;
  assign busy  = (state == StLoad) || (state == StDrain);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= StIdle;
      wr_cnt   <= '0;
      lut_ok   <= 1'b0;
      lut_err  <= 1'b0;
      checksum <= '0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          if (start) begin
            state    <= StLoad;
            wr_cnt   <= '0;
            checksum <= '0;
            lut_ok   <= 1'b0;
            lut_err  <= 1'b0;
          end
        end
        StLoad: begin
          if (beat) begin
            wr_cnt   <= wr_cnt + 1'b1;
            checksum <= checksum + 16'($signed(lt.ltdata));
            if (lt.ltlast && wr_cnt == LastAddr) begin
              state  <= StDone;
              lut_ok <= 1'b1;
            end else if (lt.ltlast) begin
              state   <= StIdle;
              lut_err <= 1'b1;
            end else if (wr_cnt == LastAddr) begin
              // Overrun: keep the final entry, swallow the rest of the frame.
              state   <= StDrain;
              lut_err <= 1'b1;
            end
          end
        end
        StDrain: begin
          if (beat && lt.ltlast) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt] <= lt.ltdata;
  end

  // Non-blocking read of mem gives read-first behaviour on a same-address write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_addr <= LastAddr) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule
